// File: rtl/key_event_pkg.sv
// Shared definitions for the key_event press decoder: FSM state encoding
// and the press counter width.
package key_event_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE = 2'd0;
    localparam key_state_t ST_HELD = 2'd1;
    localparam key_state_t ST_LONG = 2'd2;

    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/key_hold_timer.sv
// Hold-time counter for key_event: synchronous clear, count enable and an
// equality compare against a threshold supplied by the FSM each cycle.
module key_hold_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] threshold,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    // Clear has priority over counting so the FSM can restart a period on
    // the same edge it acts on the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Compare is combinational; the FSM registers everything it derives from it.
    assign hit = (count == threshold);

endmodule

// File: rtl/key_event.sv
// Key press-event decoder behind the button debouncer. Produces one-cycle
// press / release / long-press pulses, optional auto-repeat pulses and a
// wrapping press counter.
//
// Build option: define KEY_EVENT_REPEAT_EN to enable auto-repeat while the
// key stays held after the long press. Without it repeat_pulse is tied low
// and the timer idles in LONG.
//
// "release" and "repeat" are SystemVerilog keywords, so those outputs are
// named release_pulse and repeat_pulse.
//
//   state   | meaning
//   --------+--------------------------------------
//   IDLE    | key up
//   HELD    | key down, long press not yet fired
//   LONG    | key down, long press has fired
module key_event
    import key_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in,
    output logic                   press,
    output logic                   release_pulse,
    output logic                   long_press,
    output logic                   repeat_pulse,
    output logic                   held,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] LONG_TH   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TH = CNT_W'(REPEAT_CYCLES - 1);

    key_state_t       state;
    logic             tmr_clear;
    logic             tmr_enable;
    logic             tmr_hit;
    logic [CNT_W-1:0] tmr_threshold;

    key_hold_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmr_clear),
        .enable    (tmr_enable),
        .threshold (tmr_threshold),
        .hit       (tmr_hit)
    );

    // Timer control: restart on entering a timed period, count while held,
    // and leave it alone once the key is released.
    always_comb begin
        tmr_clear     = 1'b0;
        tmr_enable    = 1'b0;
        tmr_threshold = (state == ST_HELD) ? LONG_TH : REPEAT_TH;
        case (state)
            ST_IDLE: tmr_clear = in;
            ST_HELD: begin
                if (in) begin
                    tmr_clear  = tmr_hit;
                    tmr_enable = !tmr_hit;
                end
            end
            ST_LONG: begin
`ifdef KEY_EVENT_REPEAT_EN
                if (in) begin
                    tmr_clear  = tmr_hit;
                    tmr_enable = !tmr_hit;
                end
`endif
            end
            default: tmr_clear = 1'b1;
        endcase
    end

`ifdef KEY_EVENT_REPEAT_EN
    logic repeat_q;
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    // State register and registered event outputs; a release seen on the
    // same edge as a timer hit suppresses the long/repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
            press_count   <= '0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_q      <= 1'b0;
`endif
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_q      <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (in) begin
                        state       <= ST_HELD;
                        press       <= 1'b1;
                        held        <= 1'b1;
                        press_count <= press_count + PRESS_CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!in) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (tmr_hit) begin
                        state      <= ST_LONG;
                        long_press <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!in) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end
`ifdef KEY_EVENT_REPEAT_EN
                    else if (tmr_hit) begin
                        repeat_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with LONG_CYCLES=8, REPEAT_CYCLES=3.
module tb_key_event;

    localparam int LONG_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 3;
    localparam int CNT_W         = 4;

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    int n_vec;
    int n_err;

    key_event #(
        .LONG_CYCLES   (LONG_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in            (in),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .press_count   (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ep, input logic er,
                              input logic el, input logic erp, input logic eh);
        check_val({tag, ".press"},   32'(press),         32'(ep));
        check_val({tag, ".release"}, 32'(release_pulse), 32'(er));
        check_val({tag, ".long"},    32'(long_press),    32'(el));
        check_val({tag, ".repeat"},  32'(repeat_pulse),  32'(erp));
        check_val({tag, ".held"},    32'(held),          32'(eh));
    endtask

    // Apply one input level across one rising edge and check the result.
    task automatic cyc(input string tag, input logic i, input logic ep, input logic er,
                       input logic el, input logic erp, input logic eh);
        in = i;
        @(posedge clk);
        #1;
        check_outs(tag, ep, er, el, erp, eh);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset.count", 32'(press_count), 32'd0);
        rst_n = 1'b1;
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short press: four edges high, then release.
        cyc("short.k", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("short.count", 32'(press_count), 32'd1);
        for (int j = 1; j < 4; j++)
            cyc("short.hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("short.rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("short.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Long hold: high through edge k+20, long at k+8, repeats at k+11/14/17/20.
        cyc("long.k", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("long.count", 32'(press_count), 32'd2);
        for (int j = 1; j <= 20; j++) begin
            logic el, erp;
            el  = (j == 8);
            erp = REP_ON && (j == 11 || j == 14 || j == 17 || j == 20);
            cyc($sformatf("long.k+%0d", j), 1'b1, 1'b0, 1'b0, el, erp, 1'b1);
        end
        cyc("long.rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("long.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release on the long-press threshold edge: release wins.
        cyc("thr.k", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j < 8; j++)
            cyc("thr.hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("thr.k+8", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("thr.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("thr.count", 32'(press_count), 32'd3);

        // Reset while in LONG with the key held, then key still held after reset.
        cyc("rl.k", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 9; j++)
            cyc("rl.hold", 1'b1, 1'b0, 1'b0, (j == 8), 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rl.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rl.async.count", 32'(press_count), 32'd0);
        @(posedge clk);
        #1;
        check_outs("rl.inreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("rl.repress", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rl.count", 32'(press_count), 32'd1);
        cyc("rl.rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Counter wrap: 256 one-cycle presses separated by one-cycle gaps.
        hold_reset();
        for (int i = 0; i < 256; i++) begin
            cyc("wrap.press", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check_val($sformatf("wrap.count%0d", i + 1), 32'(press_count), 32'((i + 1) % 256));
            cyc("wrap.rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_val("wrap.final", 32'(press_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
